// File: rtl/cpu_probe_pkg.sv
// Shared definitions for the cpu_probe debug block: FSM state encoding,
// display-mode codes and the bit layout of the status word.
package cpu_probe_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_SCAN,
        ST_FROZEN
    } probe_state_t;

    localparam logic [2:0] MODE_PC     = 3'd0;
    localparam logic [2:0] MODE_IR     = 3'd1;
    localparam logic [2:0] MODE_ALU_A  = 3'd2;
    localparam logic [2:0] MODE_ALU_B  = 3'd3;
    localparam logic [2:0] MODE_ALU_O  = 3'd4;
    localparam logic [2:0] MODE_REG    = 3'd5;
    localparam logic [2:0] MODE_TRACE  = 3'd6;
    localparam logic [2:0] MODE_STATUS = 3'd7;

    // Status flags sit directly above the trace-count field.
    localparam int STAT_BUSY_OFS   = 0;
    localparam int STAT_FROZEN_OFS = 1;
    localparam int STAT_HALT_OFS   = 2;

endpackage

// File: rtl/cpu_probe_if.sv
// Datapath-side bundle of the probe: live CPU values in, register-file read
// port out. master = CPU datapath, slave = probe.
interface cpu_probe_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int SEL_W  = 4
);
    logic [ADDR_W-1:0] pc_i;
    logic [DATA_W-1:0] ir_i;
    logic [DATA_W-1:0] alu_a_i;
    logic [DATA_W-1:0] alu_b_i;
    logic [DATA_W-1:0] alu_o_i;
    logic              retire_i;
    logic [DATA_W-1:0] reg_data_i;
    logic [SEL_W-1:0]  reg_sel_o;
    logic              reg_read_o;

    modport master (
        output pc_i, ir_i, alu_a_i, alu_b_i, alu_o_i, retire_i, reg_data_i,
        input  reg_sel_o, reg_read_o
    );

    modport slave (
        input  pc_i, ir_i, alu_a_i, alu_b_i, alu_o_i, retire_i, reg_data_i,
        output reg_sel_o, reg_read_o
    );
endinterface

// File: rtl/cpu_probe_trace_buf.sv
// probe_trace_buf: ring buffer of retired PCs with a saturating fill count and
// a read port indexed relative to the newest entry (0 = newest).
module probe_trace_buf #(
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 8,
    parameter int IDX_W  = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_push,
    input  logic [ADDR_W-1:0] i_pc,
    input  logic [IDX_W-1:0]  i_rd_idx,
    output logic [ADDR_W-1:0] o_rd_pc,
    output logic [CNT_W-1:0]  o_count
);
    logic [ADDR_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [PTR_W-1:0]  w_rd_ptr;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_mem[gi] <= '0;
                end else if (i_push && (r_wr_ptr == PTR_W'(gi))) begin
                    r_mem[gi] <= i_pc;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (i_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (r_count != CNT_W'(DEPTH)) begin
                r_count <= r_count + CNT_W'(1);
            end
        end
    end

    // Newest entry lives one slot behind the write pointer; wrap is free.
    assign w_rd_ptr = r_wr_ptr - PTR_W'(1) - PTR_W'(i_rd_idx);
    assign o_rd_pc  = (32'(i_rd_idx) < 32'(r_count)) ? r_mem[w_rd_ptr] : '0;
    assign o_count  = r_count;

endmodule

// File: rtl/cpu_probe.sv
// cpu_probe: live/snapshot debug display with freeze, PC breakpoint, register
// shadow scan and CPU halt. PROBE_TRACE_EN adds the retired-PC trace buffer.
module cpu_probe
    import cpu_probe_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 16,
    parameter int REG_CNT     = 16,
    parameter int TRACE_DEPTH = 8,
    localparam int SEL_W      = $clog2(REG_CNT),
    localparam int CNT_W      = $clog2(TRACE_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    cpu_probe_if.slave        dp,
    input  logic [2:0]        mode_i,
    input  logic [SEL_W-1:0]  sel_i,
    input  logic              freeze_i,
    input  logic              brk_en_i,
    input  logic [ADDR_W-1:0] brk_addr_i,
    input  logic              resume_i,
    output logic              halt_o,
    output logic              busy_o,
    output logic              frozen_o,
    output logic [DATA_W-1:0] data_o
);
    localparam int PC_KEEP = (ADDR_W < DATA_W) ? ADDR_W : DATA_W;

    probe_state_t      r_state;
    logic              r_halt, r_busy, r_frozen;
    logic [SEL_W-1:0]  r_scan_idx;
    logic [ADDR_W-1:0] r_snap_pc;
    logic [DATA_W-1:0] r_snap_ir, r_snap_a, r_snap_b, r_snap_o;
    logic [DATA_W-1:0] r_shadow [REG_CNT];
    logic [DATA_W-1:0] r_data;

    logic              w_brk_hit, w_frz;
    logic [ADDR_W-1:0] w_pc_src, w_trace_pc;
    logic [CNT_W-1:0]  w_trace_cnt;
    logic [DATA_W-1:0] w_pc_ext, w_trace_ext, w_status, w_view;
    logic [SEL_W-1:0]  w_reg_sel;
    logic              w_reg_read;

    assign w_brk_hit = dp.retire_i && brk_en_i && (dp.pc_i == brk_addr_i);

`ifdef PROBE_TRACE_EN
    logic w_push;
    assign w_push = dp.retire_i && (r_state == ST_IDLE);

    probe_trace_buf #(
        .ADDR_W (ADDR_W),
        .DEPTH  (TRACE_DEPTH),
        .IDX_W  (SEL_W)
    ) u_trace (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_push   (w_push),
        .i_pc     (dp.pc_i),
        .i_rd_idx (sel_i),
        .o_rd_pc  (w_trace_pc),
        .o_count  (w_trace_cnt)
    );
`else
    assign w_trace_pc  = '0;
    assign w_trace_cnt = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_halt     <= 1'b0;
            r_busy     <= 1'b0;
            r_frozen   <= 1'b0;
            r_scan_idx <= '0;
            r_snap_pc  <= '0;
            r_snap_ir  <= '0;
            r_snap_a   <= '0;
            r_snap_b   <= '0;
            r_snap_o   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (freeze_i || w_brk_hit) begin
                        r_state <= ST_CAPTURE;
                        r_busy  <= 1'b1;
                        r_halt  <= w_brk_hit;
                    end
                end
                ST_CAPTURE: begin
                    r_snap_pc  <= dp.pc_i;
                    r_snap_ir  <= dp.ir_i;
                    r_snap_a   <= dp.alu_a_i;
                    r_snap_b   <= dp.alu_b_i;
                    r_snap_o   <= dp.alu_o_i;
                    r_scan_idx <= '0;
                    r_state    <= ST_SCAN;
                end
                ST_SCAN: begin
                    r_scan_idx <= r_scan_idx + SEL_W'(1);
                    if (r_scan_idx == SEL_W'(REG_CNT - 1)) begin
                        r_state  <= ST_FROZEN;
                        r_busy   <= 1'b0;
                        r_frozen <= 1'b1;
                    end
                end
                default: begin
                    if (resume_i) begin
                        r_halt <= 1'b0;
                    end
                    // Exit decision uses the halt currently shown, so a resume
                    // buys one more frozen cycle before returning to live view.
                    if (!freeze_i && !r_halt) begin
                        r_state  <= ST_IDLE;
                        r_frozen <= 1'b0;
                    end
                end
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < REG_CNT; gi++) begin : g_shadow
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_shadow[gi] <= '0;
                end else if ((r_state == ST_SCAN) && (r_scan_idx == SEL_W'(gi))) begin
                    r_shadow[gi] <= dp.reg_data_i;
                end
            end
        end
    endgenerate

    always_comb begin
        w_reg_sel  = '0;
        w_reg_read = 1'b0;
        if ((r_state == ST_IDLE) && (mode_i == MODE_REG)) begin
            w_reg_sel  = sel_i;
            w_reg_read = 1'b1;
        end else if (r_state == ST_SCAN) begin
            w_reg_sel  = r_scan_idx;
            w_reg_read = 1'b1;
        end
    end

    assign dp.reg_sel_o  = w_reg_sel;
    assign dp.reg_read_o = w_reg_read;

    always_comb begin
        w_frz       = (r_state == ST_FROZEN);
        w_pc_src    = w_frz ? r_snap_pc : dp.pc_i;
        w_pc_ext    = '0;
        w_pc_ext[PC_KEEP-1:0] = w_pc_src[PC_KEEP-1:0];
        w_trace_ext = '0;
        w_trace_ext[PC_KEEP-1:0] = w_trace_pc[PC_KEEP-1:0];
        w_status    = '0;
        w_status[CNT_W-1:0]               = w_trace_cnt;
        w_status[CNT_W + STAT_BUSY_OFS]   = r_busy;
        w_status[CNT_W + STAT_FROZEN_OFS] = r_frozen;
        w_status[CNT_W + STAT_HALT_OFS]   = r_halt;
        case (mode_i)
            MODE_PC:     w_view = w_pc_ext;
            MODE_IR:     w_view = w_frz ? r_snap_ir : dp.ir_i;
            MODE_ALU_A:  w_view = w_frz ? r_snap_a  : dp.alu_a_i;
            MODE_ALU_B:  w_view = w_frz ? r_snap_b  : dp.alu_b_i;
            MODE_ALU_O:  w_view = w_frz ? r_snap_o  : dp.alu_o_i;
            MODE_REG:    w_view = w_frz ? r_shadow[sel_i] : dp.reg_data_i;
            MODE_TRACE:  w_view = w_trace_ext;
            default:     w_view = w_status;
        endcase
    end

    // Display freezes on its last value while the capture/scan is running.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data <= '0;
        end else if ((r_state == ST_IDLE) || (r_state == ST_FROZEN)) begin
            r_data <= w_view;
        end
    end

    assign halt_o   = r_halt;
    assign busy_o   = r_busy;
    assign frozen_o = r_frozen;
    assign data_o   = r_data;

endmodule

// File: tb/tb_cpu_probe.sv
// Self-checking bench for cpu_probe: directed scenarios plus random traffic,
// checked cycle by cycle against a behavioural model through a scoreboard.
module tb_cpu_probe;
    localparam int REG_CNT     = 16;
    localparam int TRACE_DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  mode;
    logic [3:0]  sel;
    logic        freeze, brk_en, resume;
    logic [15:0] brk_addr;
    logic        halt, busy, frozen;
    logic [15:0] data;
    logic [15:0] regfile [REG_CNT];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    cpu_probe_if dp_if ();
    assign dp_if.reg_data_i = regfile[dp_if.reg_sel_o];

    cpu_probe dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .dp         (dp_if),
        .mode_i     (mode),
        .sel_i      (sel),
        .freeze_i   (freeze),
        .brk_en_i   (brk_en),
        .brk_addr_i (brk_addr),
        .resume_i   (resume),
        .halt_o     (halt),
        .busy_o     (busy),
        .frozen_o   (frozen),
        .data_o     (data)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [15:0] data;
        bit          halt;
        bit          busy;
        bit          frozen;
    } exp_t;

    exp_t        sbq [$];
    int          m_busy;      // busy cycles still to come (capture + scan)
    bit          m_frozen, m_halt;
    logic [15:0] m_data;
    logic [15:0] m_snap_pc, m_snap_ir, m_snap_a, m_snap_b, m_snap_o;
    logic [15:0] m_shadow [REG_CNT];
    logic [15:0] m_trace [$];  // index 0 = newest

    task automatic model_reset();
        m_busy = 0; m_frozen = 0; m_halt = 0; m_data = '0;
        m_snap_pc = '0; m_snap_ir = '0; m_snap_a = '0; m_snap_b = '0; m_snap_o = '0;
        for (int i = 0; i < REG_CNT; i++) m_shadow[i] = '0;
        m_trace.delete();
        sbq.delete();
    endtask

    function automatic logic [15:0] model_view();
        logic [3:0] cnt;
        cnt = '0;
`ifdef PROBE_TRACE_EN
        cnt = 4'(m_trace.size());
`endif
        case (mode)
            3'd0: return m_frozen ? m_snap_pc : dp_if.pc_i;
            3'd1: return m_frozen ? m_snap_ir : dp_if.ir_i;
            3'd2: return m_frozen ? m_snap_a  : dp_if.alu_a_i;
            3'd3: return m_frozen ? m_snap_b  : dp_if.alu_b_i;
            3'd4: return m_frozen ? m_snap_o  : dp_if.alu_o_i;
            3'd5: return m_frozen ? m_shadow[sel] : regfile[sel];
            3'd6: begin
`ifdef PROBE_TRACE_EN
                if (int'(sel) < m_trace.size()) return m_trace[int'(sel)];
`endif
                return 16'h0;
            end
            default: return {9'b0, m_halt, m_frozen, 1'b0, cnt};
        endcase
    endfunction

    task automatic model_step();
        bit idle, hit, old_halt;
        int k;
        idle = (m_busy == 0) && !m_frozen;
        hit  = dp_if.retire_i && brk_en && (dp_if.pc_i == brk_addr);
        if (idle || m_frozen) m_data = model_view();
`ifdef PROBE_TRACE_EN
        if (idle && dp_if.retire_i) begin
            m_trace.push_front(dp_if.pc_i);
            if (m_trace.size() > TRACE_DEPTH) m_trace.delete(TRACE_DEPTH);
        end
`endif
        if (idle) begin
            if (freeze || hit) begin
                m_busy = REG_CNT + 1;
                m_halt = hit;
            end
        end else if (m_busy == REG_CNT + 1) begin
            m_snap_pc = dp_if.pc_i;    m_snap_ir = dp_if.ir_i;
            m_snap_a  = dp_if.alu_a_i; m_snap_b  = dp_if.alu_b_i;
            m_snap_o  = dp_if.alu_o_i;
            m_busy--;
        end else if (m_busy > 0) begin
            k = REG_CNT - m_busy;
            m_shadow[k] = regfile[k];
            m_busy--;
            if (m_busy == 0) m_frozen = 1;
        end else begin
            old_halt = m_halt;
            if (resume) m_halt = 0;
            if (!freeze && !old_halt) m_frozen = 0;
        end
        sbq.push_back('{data: m_data, halt: m_halt, busy: (m_busy != 0), frozen: m_frozen});
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            if (rst_n !== 1'b1) model_reset();
            else model_step();
        end
    end

    always @(negedge rst_n) model_reset();

    // ---------------- monitor ----------------
    initial begin
        exp_t       e;
        logic [4:0] exp_port;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && sbq.size() > 0) begin
                e = sbq.pop_front();
                check("sb_data", 32'(data), 32'(e.data));
                check("sb_flags", {29'b0, halt, busy, frozen}, {29'b0, e.halt, e.busy, e.frozen});
                exp_port = '0;
                if (m_busy == 0 && !m_frozen && mode == 3'd5) exp_port = {1'b1, sel};
                else if (m_busy > 0 && m_busy <= REG_CNT) exp_port = {1'b1, 4'(REG_CNT - m_busy)};
                check("sb_regport", {27'b0, dp_if.reg_read_o, dp_if.reg_sel_o}, {27'b0, exp_port});
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int cnt;
        logic [15:0] exp_tr0, exp_tr7, exp_cnt;
        rst_n = 1'b0;
        mode = 3'd0; sel = '0; freeze = 0; brk_en = 0; resume = 0; brk_addr = '0;
        dp_if.pc_i = '0; dp_if.ir_i = '0; dp_if.alu_a_i = '0; dp_if.alu_b_i = '0;
        dp_if.alu_o_i = '0; dp_if.retire_i = 0;
        for (int i = 0; i < REG_CNT; i++) regfile[i] = 16'($urandom);

        repeat (3) tick();
        check("reset_out", {11'b0, halt, busy, frozen, data}, 32'h0);
        rst_n = 1'b1;
        $display("tx reset released");

        dp_if.pc_i = 16'h2333; tick();
        check("live_pc", 32'(data), 32'h2333);
        $display("tx live mode0 pc=2333 data=%h", data);

        mode = 3'd2; dp_if.alu_a_i = 16'h1000; tick();
        check("live_alu_a", 32'(data), 32'h1000);
        $display("tx live mode2 alu_a=1000 data=%h", data);

        mode = 3'd5; sel = 4'd3; regfile[3] = 16'h2000; #1;
        check("idle_reg_port", {27'b0, dp_if.reg_read_o, dp_if.reg_sel_o}, 32'h13);
        tick();
        check("idle_reg_data", 32'(data), 32'h2000);
        $display("tx idle reg read sel=3 data=%h", data);

        for (int i = 0; i < REG_CNT; i++) regfile[i] = 16'hA000 + 16'(i);
        mode = 3'd0; freeze = 1; tick();
        cnt = 0;
        while (busy === 1'b1 && cnt < 40) begin cnt++; tick(); end
        check("busy_len", cnt, 17);
        check("freeze_frozen", 32'(frozen), 32'h1);
        mode = 3'd5; sel = 4'd7; dp_if.pc_i = 16'h5A5A;
        for (int i = 0; i < REG_CNT; i++) regfile[i] = 16'($urandom);
        tick();
        check("frozen_reg7", 32'(data), 32'hA007);
        mode = 3'd0; tick();
        check("frozen_pc", 32'(data), 32'h2333);
        freeze = 0; tick();
        check("unfreeze", 32'(frozen), 32'h0);
        $display("tx freeze/scan busy=%0d cycles, shadow7 ok", cnt);

        brk_addr = 16'h0040; brk_en = 1; dp_if.pc_i = 16'h0040; dp_if.retire_i = 1; tick();
        dp_if.retire_i = 0; brk_en = 0;
        check("brk_halt", {30'b0, halt, busy}, 32'h3);
        cnt = 0;
        while (frozen !== 1'b1 && cnt < 40) begin cnt++; tick(); end
        check("brk_frozen", {30'b0, halt, frozen}, 32'h3);
        resume = 1; tick(); resume = 0;
        check("resume_halt", 32'(halt), 32'h0);
        tick();
        check("resume_idle", 32'(frozen), 32'h0);
        $display("tx breakpoint at 0040 halted and resumed");

        mode = 3'd0; brk_en = 1; dp_if.retire_i = 1; tick();
        dp_if.retire_i = 0; brk_en = 0;
        repeat (4) tick();
        check("busy_before_rst", {30'b0, halt, busy}, 32'h3);
        #2 rst_n = 1'b0;
        #1;
        check("rst_midscan", {11'b0, halt, busy, frozen, data}, 32'h0);
        tick(); rst_n = 1'b1;
        mode = 3'd7; tick();
        check("rst_status", 32'(data), 32'h0);
        $display("tx reset during scan");

        mode = 3'd0;
        for (int i = 1; i <= 10; i++) begin
            dp_if.pc_i = 16'(i); dp_if.retire_i = 1; tick();
        end
        dp_if.retire_i = 0;
`ifdef PROBE_TRACE_EN
        exp_tr0 = 16'd10; exp_tr7 = 16'd3; exp_cnt = 16'd8;
`else
        exp_tr0 = 16'd0;  exp_tr7 = 16'd0; exp_cnt = 16'd0;
`endif
        mode = 3'd6; sel = 4'd0; tick();
        check("trace0", 32'(data), 32'(exp_tr0));
        sel = 4'd7; tick();
        check("trace7", 32'(data), 32'(exp_tr7));
        sel = 4'd9; tick();
        check("trace_oob", 32'(data), 32'h0);
        mode = 3'd7; tick();
        check("status_cnt", 32'(data), 32'(exp_cnt));
        $display("tx trace of 10 retires");

        brk_addr = 16'h0010;
        for (int b = 0; b < 16; b++) begin
            for (int c = 0; c < 100; c++) begin
                mode = 3'($urandom); sel = 4'($urandom);
                if ($urandom_range(0, 24) == 0) freeze = ~freeze;
                brk_en = ($urandom_range(0, 3) == 0);
                resume = ($urandom_range(0, 7) == 0);
                dp_if.retire_i = ($urandom_range(0, 2) == 0);
                dp_if.pc_i = 16'($urandom_range(0, 31));
                dp_if.ir_i = 16'($urandom); dp_if.alu_a_i = 16'($urandom);
                dp_if.alu_b_i = 16'($urandom); dp_if.alu_o_i = 16'($urandom);
                regfile[$urandom_range(0, REG_CNT - 1)] = 16'($urandom);
                if (b == 9 && c == 50) begin
                    rst_n = 1'b0; tick(); tick(); rst_n = 1'b1;
                end
                tick();
            end
            $display("tx random burst %0d done, errors so far %0d", b, errors);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
